// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - multi-cycle load/store unit; MEM_MISALIGNED_SPLIT_EN enables split misaligned accesses
package mem_access_ctrl_pkg;
    typedef struct packed {
        logic       is_write;
        logic       is_unsigned;
        logic [1:0] op_size;
    } mem_microcode_t;
endpackage

module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  mem_microcode_t       microcode,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          in,
    output logic [31:0]          out,
    output logic [2:0]           fault_num,
    output logic                 done,
    output logic                 busy,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [3:0]           bus_be,
    output logic [31:0]          bus_wdata,
    input  logic [31:0]          bus_rdata,
    input  logic                 bus_ack,
    input  logic                 bus_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
`ifdef MEM_MISALIGNED_SPLIT_EN
    localparam logic [1:0] S_ACC1 = 2'd2;
`endif
    localparam logic [1:0] S_RESP = 2'd3;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] tmo_cnt;
    logic          is_write_q;
    logic          is_unsigned_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;

    logic [3:0]  mask;
    logic [3:0]  be_lo;
    logic [31:0] wd_lo;
    logic        size_bad;
    logic        misaligned;
    logic [5:0]  sh;
    logic [31:0] assembled;
    logic [31:0] load_val;

    always_comb begin
        case (microcode.op_size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    assign size_bad = (microcode.op_size == 2'b11);
    assign sh       = {1'b0, off_q, 3'b000};

`ifdef MEM_MISALIGNED_SPLIT_EN
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic        cross_in;
    logic        cross_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wd_hi_q;
    logic [31:0] rdata0_q;

    // The upper half of the widened lane shift is exactly the second-word lanes/data.
    assign be_wide    = {4'b0000, mask} << addr[1:0];
    assign wd_wide    = {32'b0, in} << {addr[1:0], 3'b000};
    assign cross_in   = |be_wide[7:4];
    assign be_lo      = be_wide[3:0];
    assign wd_lo      = wd_wide[31:0];
    assign misaligned = 1'b0;

    always_comb begin
        if (state == S_ACC1)
            assembled = (rdata0_q >> sh) | (bus_rdata << (6'd32 - sh));
        else
            assembled = bus_rdata >> sh;
    end
`else
    assign be_lo      = mask << addr[1:0];
    assign wd_lo      = in << {addr[1:0], 3'b000};
    assign misaligned = ((microcode.op_size == 2'b01) && addr[0]) ||
                        ((microcode.op_size == 2'b10) && (addr[1:0] != 2'b00));
    assign assembled  = bus_rdata >> sh;
`endif

    always_comb begin
        case (size_q)
            2'b00:   load_val = is_unsigned_q ? {24'b0, assembled[7:0]}
                                              : {{24{assembled[7]}}, assembled[7:0]};
            2'b01:   load_val = is_unsigned_q ? {16'b0, assembled[15:0]}
                                              : {{16{assembled[15]}}, assembled[15:0]};
            default: load_val = assembled;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            tmo_cnt       <= '0;
            is_write_q    <= 1'b0;
            is_unsigned_q <= 1'b0;
            size_q        <= 2'b00;
            off_q         <= 2'b00;
            out           <= 32'b0;
            fault_num     <= 3'b000;
            done          <= 1'b0;
            busy          <= 1'b0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_be        <= 4'b0;
            bus_wdata     <= 32'b0;
`ifdef MEM_MISALIGNED_SPLIT_EN
            cross_q       <= 1'b0;
            be_hi_q       <= 4'b0;
            wd_hi_q       <= 32'b0;
            rdata0_q      <= 32'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_write_q    <= microcode.is_write;
                        is_unsigned_q <= microcode.is_unsigned;
                        size_q        <= microcode.op_size;
                        off_q         <= addr[1:0];
                        busy          <= 1'b1;
                        if (size_bad || misaligned) begin
                            state     <= S_RESP;
                            done      <= 1'b1;
                            out       <= 32'b0;
                            fault_num <= {1'b1, microcode.is_write, 1'b0};
                        end else begin
                            state     <= S_ACC0;
                            tmo_cnt   <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= microcode.is_write;
                            bus_addr  <= {addr[ADDR_BITS-1:2], 2'b00};
                            bus_be    <= be_lo;
                            bus_wdata <= wd_lo;
`ifdef MEM_MISALIGNED_SPLIT_EN
                            cross_q   <= cross_in;
                            be_hi_q   <= be_wide[7:4];
                            wd_hi_q   <= wd_wide[63:32];
`endif
                        end
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    // Error beats a simultaneous ack; silence for the full budget is an access fault.
                    if (bus_err || (!bus_ack && tmo_cnt == TMO_LAST)) begin
                        state     <= S_RESP;
                        done      <= 1'b1;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_be    <= 4'b0;
                        out       <= 32'b0;
                        fault_num <= {1'b1, is_write_q, 1'b1};
                    end else if (bus_ack) begin
`ifdef MEM_MISALIGNED_SPLIT_EN
                        if (state == S_ACC0 && cross_q) begin
                            state     <= S_ACC1;
                            tmo_cnt   <= '0;
                            rdata0_q  <= bus_rdata;
                            bus_addr  <= bus_addr + ADDR_BITS'(4);
                            bus_be    <= be_hi_q;
                            bus_wdata <= wd_hi_q;
                        end else
`endif
                        begin
                            state     <= S_RESP;
                            done      <= 1'b1;
                            bus_req   <= 1'b0;
                            bus_we    <= 1'b0;
                            bus_be    <= 4'b0;
                            out       <= is_write_q ? 32'b0 : load_val;
                            fault_num <= 3'b000;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    mem_microcode_t mc = '0;
    logic [31:0]    addr = '0;
    logic [31:0]    wdin = '0;
    logic [31:0]    out;
    logic [2:0]     fault_num;
    logic           done, busy, bus_req, bus_we;
    logic [31:0]    bus_addr;
    logic [3:0]     bus_be;
    logic [31:0]    bus_wdata;
    logic [31:0]    bus_rdata = '0;
    logic           bus_ack = 1'b0;
    logic           bus_err = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_BITS(32), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .microcode(mc),
        .addr(addr), .in(wdin), .out(out), .fault_num(fault_num),
        .done(done), .busy(busy), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input logic w, input logic u, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        mc = {w, u, sz}; addr = a; wdin = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mc = '0; addr = '0; wdin = '0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({done, busy, bus_req, bus_we} !== 4'b0000) begin n_errors++; $display("FAIL reset_ctrl: got %b expected 0000", {done, busy, bus_req, bus_we}); end
        n_checks++; if (out !== 32'h0 || fault_num !== 3'b000) begin n_errors++; $display("FAIL reset_out: got %h/%b expected 0/000", out, fault_num); end
        n_checks++; if (bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_bus: got %h/%b/%h expected zeros", bus_addr, bus_be, bus_wdata); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lbu;
        issue(1'b0, 1'b1, 2'b00, 32'h2000_0003, 32'h0);
        n_checks++; if (bus_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL lbu_req: got req=%b busy=%b done=%b expected 1 1 0", bus_req, busy, done); end
        n_checks++; if (bus_be !== 4'b1000 || bus_addr !== 32'h2000_0000 || bus_we !== 1'b0) begin n_errors++; $display("FAIL lbu_bus: got be=%b addr=%h we=%b expected 1000 20000000 0", bus_be, bus_addr, bus_we); end
        bus_ack = 1'b1; bus_rdata = 32'h80FF_0000;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b1 || bus_req !== 1'b0) begin n_errors++; $display("FAIL lbu_done: got done=%b busy=%b req=%b expected 1 1 0", done, busy, bus_req); end
        n_checks++; if (out !== 32'h0000_0080 || fault_num !== 3'b000) begin n_errors++; $display("FAIL lbu_out: got %h/%b expected 00000080/000", out, fault_num); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || out !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu_after: got done=%b busy=%b out=%h expected 0 0 00000080", done, busy, out); end
    endtask

    task automatic test_lh_wait;
        issue(1'b0, 1'b0, 2'b01, 32'h2000_0002, 32'h0);
        n_checks++; if (bus_be !== 4'b1100) begin n_errors++; $display("FAIL lh_be: got %b expected 1100", bus_be); end
        repeat (2) @(negedge clk);
        n_checks++; if (bus_req !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL lh_wait: got req=%b done=%b expected 1 0", bus_req, done); end
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h8001_0000;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        n_checks++; if (done !== 1'b1 || out !== 32'hFFFF_8001 || fault_num !== 3'b000) begin n_errors++; $display("FAIL lh_out: got done=%b out=%h fault=%b expected 1 ffff8001 000", done, out, fault_num); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int bad = 0;
        issue(1'b0, 1'b0, 2'b10, 32'h2000_0010, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            if (bus_req !== 1'b1 || done !== 1'b0) bad++;
            if (k < 15) @(negedge clk);
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL timeout_hold: got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || fault_num !== 3'b101 || out !== 32'h0 || bus_req !== 1'b0) begin n_errors++; $display("FAIL timeout_fault: got done=%b fault=%b out=%h req=%b expected 1 101 0 0", done, fault_num, out, bus_req); end
        @(negedge clk);
    endtask

    task automatic test_store_misaligned;
        issue(1'b1, 1'b0, 2'b10, 32'h2000_0001, 32'hAABB_CCDD);
`ifdef MEM_MISALIGNED_SPLIT_EN
        n_checks++; if (bus_addr !== 32'h2000_0000 || bus_be !== 4'b1110 || bus_wdata !== 32'hBBCC_DD00 || bus_we !== 1'b1) begin n_errors++; $display("FAIL sw_ph0: got %h %b %h we=%b expected 20000000 1110 bbccdd00 1", bus_addr, bus_be, bus_wdata, bus_we); end
        bus_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h2000_0004 || bus_be !== 4'b0001 || bus_wdata !== 32'h0000_00AA) begin n_errors++; $display("FAIL sw_ph1: got req=%b %h %b %h expected 1 20000004 0001 000000aa", bus_req, bus_addr, bus_be, bus_wdata); end
        @(negedge clk);
        bus_ack = 1'b0;
        n_checks++; if (done !== 1'b1 || fault_num !== 3'b000) begin n_errors++; $display("FAIL sw_split_done: got done=%b fault=%b expected 1 000", done, fault_num); end
`else
        n_checks++; if (done !== 1'b1 || fault_num !== 3'b110 || bus_req !== 1'b0) begin n_errors++; $display("FAIL sw_misaligned: got done=%b fault=%b req=%b expected 1 110 0", done, fault_num, bus_req); end
`endif
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || bus_req !== 1'b0) begin n_errors++; $display("FAIL sw_idle: got busy=%b req=%b expected 0 0", busy, bus_req); end
    endtask

    task automatic test_err_ack;
        issue(1'b1, 1'b0, 2'b01, 32'h2000_0000, 32'h0000_1234);
        n_checks++; if (bus_be !== 4'b0011 || bus_wdata !== 32'h0000_1234 || bus_we !== 1'b1) begin n_errors++; $display("FAIL sh_bus: got %b %h we=%b expected 0011 00001234 1", bus_be, bus_wdata, bus_we); end
        bus_ack = 1'b1; bus_err = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0; bus_err = 1'b0;
        n_checks++; if (done !== 1'b1 || fault_num !== 3'b111 || out !== 32'h0) begin n_errors++; $display("FAIL sh_err: got done=%b fault=%b out=%h expected 1 111 0", done, fault_num, out); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        mc = {1'b0, 1'b0, 2'b10}; addr = 32'h2000_0008; start = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h2000_0008) begin n_errors++; $display("FAIL b2b_first: got req=%b addr=%h expected 1 20000008", bus_req, bus_addr); end
        addr = 32'h2000_0100; bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        n_checks++; if (done !== 1'b1 || out !== 32'h1122_3344) begin n_errors++; $display("FAIL b2b_first_out: got done=%b out=%h expected 1 11223344", done, out); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || bus_req !== 1'b0) begin n_errors++; $display("FAIL b2b_resp_ignore: got busy=%b req=%b expected 0 0", busy, bus_req); end
        @(negedge clk);
        start = 1'b0; mc = '0; addr = '0;
        n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h2000_0100) begin n_errors++; $display("FAIL b2b_second: got req=%b addr=%h expected 1 20000100", bus_req, bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_BABE;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        n_checks++; if (done !== 1'b1 || out !== 32'hCAFE_BABE) begin n_errors++; $display("FAIL b2b_second_out: got done=%b out=%h expected 1 cafebabe", done, out); end
        @(negedge clk);
    endtask

    task automatic test_invalid_size;
        issue(1'b0, 1'b0, 2'b11, 32'h2000_0000, 32'h0);
        n_checks++; if (done !== 1'b1 || fault_num !== 3'b100 || bus_req !== 1'b0 || out !== 32'h0) begin n_errors++; $display("FAIL inv_load: got done=%b fault=%b req=%b out=%h expected 1 100 0 0", done, fault_num, bus_req, out); end
        @(negedge clk);
        issue(1'b1, 1'b0, 2'b11, 32'h2000_0000, 32'h0);
        n_checks++; if (done !== 1'b1 || fault_num !== 3'b110 || bus_req !== 1'b0) begin n_errors++; $display("FAIL inv_store: got done=%b fault=%b req=%b expected 1 110 0", done, fault_num, bus_req); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 1'b0, 2'b10, 32'h2000_0020, 32'h0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid: got req=%b done=%b busy=%b expected 0 0 0", bus_req, done, busy); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_mid_nodone: got %b expected 0", done); end
        issue(1'b0, 1'b0, 2'b00, 32'h2000_0001, 32'h0);
        n_checks++; if (bus_req !== 1'b1 || bus_be !== 4'b0010) begin n_errors++; $display("FAIL rst_next_bus: got req=%b be=%b expected 1 0010", bus_req, bus_be); end
        bus_ack = 1'b1; bus_rdata = 32'h0000_8000;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        n_checks++; if (done !== 1'b1 || out !== 32'hFFFF_FF80 || fault_num !== 3'b000) begin n_errors++; $display("FAIL rst_next_out: got done=%b out=%h fault=%b expected 1 ffffff80 000", done, out, fault_num); end
        @(negedge clk);
    endtask

    task automatic test_half_o1;
        issue(1'b0, 1'b1, 2'b01, 32'h2000_0001, 32'h0);
`ifdef MEM_MISALIGNED_SPLIT_EN
        n_checks++; if (bus_be !== 4'b0110 || bus_req !== 1'b1) begin n_errors++; $display("FAIL lhu_o1_be: got be=%b req=%b expected 0110 1", bus_be, bus_req); end
        bus_ack = 1'b1; bus_rdata = 32'h00FE_DC00;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        n_checks++; if (done !== 1'b1 || out !== 32'h0000_FEDC || fault_num !== 3'b000) begin n_errors++; $display("FAIL lhu_o1_out: got done=%b out=%h fault=%b expected 1 0000fedc 000", done, out, fault_num); end
`else
        n_checks++; if (done !== 1'b1 || fault_num !== 3'b100 || bus_req !== 1'b0) begin n_errors++; $display("FAIL lhu_o1_fault: got done=%b fault=%b req=%b expected 1 100 0", done, fault_num, bus_req); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lbu();
        test_lh_wait();
        test_timeout();
        test_store_misaligned();
        test_err_ack();
        test_back_to_back();
        test_invalid_size();
        test_reset_mid();
        test_half_o1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle load/store unit that sits between the execute stage and the external memory bus, replacing the single-cycle memory access path. It accepts one request per start pulse, drives a word-wide request/acknowledge bus with byte enables, sign/zero-extends loads, and reports alignment and access faults. Bus wait states are tolerated up to a programmable timeout. Misaligned accesses can optionally be split into two aligned bus transactions.

## Interface
- ADDR_BITS, 32, width of byte address and bus address
- TIMEOUT_CYCLES, 15, max request cycles without ack/err before an access fault (≥1)

- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request pulse; accepted only when busy=0
- microcode  in  mem_microcode_t  is_write, is_unsigned, op_size (00 byte, 01 half, 10 word, 11 invalid)
- addr  in  ADDR_BITS  byte address
- in  in  32  store data (low bytes used for byte/half)
- out  out  32  load result, extended
- fault_num  out  3  100 load misaligned, 101 load access, 110 store misaligned, 111 store access, 000 none
- done  out  1  one-cycle completion pulse
- busy  out  1  high from cycle after accepted start through done cycle
- bus_req  out  1  bus request, held until ack/err/timeout
- bus_we  out  1  write strobe
- bus_addr  out  ADDR_BITS  word-aligned address ([1:0]=00)
- bus_be  out  4  byte-lane enables
- bus_wdata  out  32  lane-aligned write data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  transaction complete
- bus_err  in  1  transaction failed

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: on start, capture microcode, addr, in (need not be held afterwards). Offset o=addr[1:0], size n∈{1,2,4}.
- Invalid op_size → RESP with misaligned fault. Misaligned (half with o odd, word with o≠0): see Configuration. Otherwise → ACC0.
- ACC0: bus_req=1, bus_addr={addr[ADDR_BITS-1:2],00}, bus_be=((1<<n)-1)<<o truncated to 4 bits, bus_wdata=in<<8o, bus_we=is_write.
- On bus_ack: latch bus_rdata; if access crosses a word → ACC1, else RESP.
- ACC1: bus_addr = phase-0 word address + 4 (wraps modulo 2^ADDR_BITS), bus_be=((1<<n)-1)>>(4-o), bus_wdata=in>>8(4-o). On ack → RESP.
- bus_err, or TIMEOUT_CYCLES consecutive request cycles without ack → RESP with access fault (101/111). bus_err and bus_ack in same cycle: err wins. Timeout counter clears at each new phase.
- Phase-1 fault on a split store does not undo phase-0 write.
- Load assembly: data=(rdata0>>8o)|(rdata1<<8(4-o)); byte/half sign-extended from bit 7/15 unless is_unsigned; word unchanged.
- RESP: done=1, busy=1; → IDLE. out and fault_num registered on entry to RESP and held until the next RESP; out=0 on any fault; fault_num=000 on success.
- start while busy is ignored; start in the RESP cycle is ignored.

## Timing
- Reset (reset_n=0 at edge): state IDLE, out=0, fault_num=000, done=0, busy=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, timeout counter 0. Reset mid-transaction drops bus_req at that edge; no done.
- Start at edge T: bus_req high from T+1. Zero-wait aligned access: ack at T+1, done at T+2. Split: done at T+3. Each wait state adds one cycle.
- Decode fault: done at T+1, no bus_req.
- Timeout: request cycles T+1..T+TIMEOUT_CYCLES, done at T+TIMEOUT_CYCLES+1.
- Bus outputs are registered and stable while bus_req=1.

## Configuration
- MEM_MISALIGNED_SPLIT_EN defined: misaligned half/word accesses execute as one or two aligned bus transactions (ACC0/ACC1) and complete without fault; a half at o=1 stays in one word.
- Undefined: ACC1 is not built; any misaligned access → RESP with fault 100 (load) / 110 (store), no bus_req.

## Test plan
- Reset, then lbu addr 0x20000003, rdata 0x80FF0000 on first-cycle ack → bus_be=1000, done at T+2, out=0x00000080, fault 000.
- lh addr 0x20000002, rdata 0x8001_0000, 3 wait states → out=0xFFFF8001, done at T+5.
- sw addr 0x20000001, in 0xAABBCCDD, split enabled → ACC0 be=1110 wdata=0xBBCCDD00 addr 0x20000000; ACC1 be=0001 wdata=0x000000AA addr 0x20000004; fault 000. Split disabled → fault 110 at T+1, no bus_req.
- lw, bus never responds → done at T+16, fault 101, out=0.
- sh, bus_err with bus_ack same cycle → fault 111; op_size 11 → fault 100/110 at T+1.
- reset_n low during ACC0 wait → bus_req 0 next edge, no done, next start proceeds normally.
